// File: rtl/philv_mem_arbiter_pkg.sv
// Shared types and constants for the philosophy-v memory arbiter.
package philv_pkg;

  localparam int unsigned PHILV_XLEN = 32;
  localparam int unsigned PHILV_BE_W = 4;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/philv_mem_arbiter_if.sv
// IF/DM request ports and memory macro bus; slave = arbiter, master = core + memory.
interface philv_mem_arbiter_if
  import philv_pkg::*;
#(
  parameter int unsigned ADDR_W = PHILV_XLEN,
  parameter int unsigned DATA_W = PHILV_XLEN
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/philv_mem_arbiter_pick.sv
// Priority policy: DM wins unless the starvation guard has tripped with IF waiting.
module philv_arb_pick (
  input  logic if_req,
  input  logic dm_req,
  input  logic starve_hit,
  output logic grant_if,
  output logic grant_dm
);

  assign grant_dm = dm_req & ~(starve_hit & if_req);
  assign grant_if = if_req & (~dm_req | starve_hit);

endmodule

// File: rtl/philv_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IF and DM.
// Optional perf wait counters are enabled by defining PHILV_ARB_PERF_EN.
module philv_mem_arbiter
  import philv_pkg::*;
#(
  parameter int unsigned ADDR_W     = PHILV_XLEN,
  parameter int unsigned DATA_W     = PHILV_XLEN,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rstb,
  philv_mem_arbiter_if.slave  bus
`ifdef PHILV_ARB_PERF_EN
  ,
  output logic [31:0]         perf_if_wait,
  output logic [31:0]         perf_dm_wait
`endif
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  localparam logic [0:0] StIdle = ARB_IDLE;
  localparam logic [0:0] StBusy = ARB_BUSY;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [StW-1:0]  starve_q, starve_d;

  logic idle, starve_hit, grant_if, grant_dm, done;

  // Grants only in IDLE and never while reset is asserted.
  assign idle       = (state_q == StIdle) && !rstb;
  assign starve_hit = (starve_q == StW'(STARVE_MAX));
  assign done       = (state_q == StBusy) && (cnt_q == CntW'(1)) && !rstb;

  philv_arb_pick u_pick (
    .if_req     (bus.if_req & idle),
    .dm_req     (bus.dm_req & idle),
    .starve_hit (starve_hit),
    .grant_if   (grant_if),
    .grant_dm   (grant_dm)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    if (grant_if || grant_dm) begin
      state_d = StBusy;
      cnt_d   = CntW'(MEM_LAT);
      owner_d = grant_dm ? OWN_DM : OWN_IF;
      we_d    = grant_dm & bus.dm_we;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q - CntW'(1);
      if (done) state_d = StIdle;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || grant_if) begin
      starve_d = '0;
    end else if (grant_dm && !starve_hit) begin
      starve_d = starve_q + StW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      owner_q  <= OWN_IF;
      we_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      starve_q <= starve_d;
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.dm_gnt    = grant_dm;
  assign bus.mem_en    = grant_if | grant_dm;
  assign bus.mem_we    = grant_dm & bus.dm_we;
  assign bus.mem_addr  = grant_dm ? bus.dm_addr  : (grant_if ? bus.if_addr : ADDR_W'(0));
  assign bus.mem_wdata = grant_dm ? bus.dm_wdata : DATA_W'(0);
  assign bus.mem_be    = grant_dm ? bus.dm_be    : (grant_if ? '1 : '0);

  assign bus.if_rvalid = done && (owner_q == OWN_IF);
  assign bus.dm_rvalid = done && (owner_q == OWN_DM);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : DATA_W'(0);
  assign bus.dm_rdata  = (bus.dm_rvalid && !we_q) ? bus.mem_rdata : DATA_W'(0);

`ifdef PHILV_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rstb) begin
      perf_if_wait <= '0;
      perf_dm_wait <= '0;
    end else begin
      if (bus.if_req && !grant_if && (perf_if_wait != '1)) perf_if_wait <= perf_if_wait + 32'd1;
      if (bus.dm_req && !grant_dm && (perf_dm_wait != '1)) perf_dm_wait <= perf_dm_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_philv_mem_arbiter.sv
// Scoreboard bench for philv_mem_arbiter; perf checks compile in with PHILV_ARB_PERF_EN.
module tb_philv_mem_arbiter;
  import philv_pkg::*;

  typedef struct {
    bit                    dm;
    int                    cyc;
    logic [31:0]           addr;
    bit                    we;
    logic [PHILV_BE_W-1:0] be;
    bit                    chk_wd;
    logic [31:0]           wdata;
  } gnt_t;

  typedef struct {
    bit          dm;
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rstb = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  gnt_t gq[$];
  rsp_t rq[$];

  philv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef PHILV_ARB_PERF_EN
  logic [31:0] perf_if_wait, perf_dm_wait;
`endif

  philv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .bus          (bus)
`ifdef PHILV_ARB_PERF_EN
    ,
    .perf_if_wait (perf_if_wait),
    .perf_dm_wait (perf_dm_wait)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_val(logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (32'h0BAD0000 ^ a);
  endfunction

  // Memory model: read data appears two cycles after the command cycle.
  logic v1 = 1'b0, v2 = 1'b0;
  logic [31:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    v1 <= bus.mem_en & ~bus.mem_we;
    a1 <= bus.mem_addr;
    v2 <= v1;
    a2 <= a1;
  end
  assign bus.mem_rdata = v2 ? mem_val(a2) : 32'h5555AAAA;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a grant or a response.
  always @(negedge clk) begin
    gnt_t g;
    rsp_t r;
    if (bus.if_gnt || bus.dm_gnt || bus.mem_en) begin
      if (gq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_grant: got grant at cycle %0d, required none", cyc);
      end else begin
        g = gq.pop_front();
        chk("gnt_cycle", cyc, g.cyc);
        chk("dm_gnt", {31'b0, bus.dm_gnt}, {31'b0, g.dm});
        chk("if_gnt", {31'b0, bus.if_gnt}, {31'b0, !g.dm});
        chk("mem_en", {31'b0, bus.mem_en}, 32'd1);
        chk("mem_addr", bus.mem_addr, g.addr);
        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, g.we});
        chk("mem_be", {28'b0, bus.mem_be}, {28'b0, g.be});
        if (g.chk_wd) chk("mem_wdata", bus.mem_wdata, g.wdata);
      end
    end else begin
      chk("idle_bus", {27'b0, bus.mem_we, |bus.mem_addr, |bus.mem_wdata, |bus.mem_be, 1'b0}, 32'd0);
    end
    if (bus.if_rvalid || bus.dm_rvalid) begin
      if (rq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rvalid at cycle %0d, required none", cyc);
      end else begin
        r = rq.pop_front();
        chk("rvalid_cycle", cyc, r.cyc);
        chk("dm_rvalid", {31'b0, bus.dm_rvalid}, {31'b0, r.dm});
        chk("if_rvalid", {31'b0, bus.if_rvalid}, {31'b0, !r.dm});
        chk("rdata", r.dm ? bus.dm_rdata : bus.if_rdata, r.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(bit dm, int c, logic [31:0] addr, bit we, logic [3:0] be,
                          bit chk_wd, logic [31:0] wdata);
    gnt_t g;
    g.dm = dm; g.cyc = c; g.addr = addr; g.we = we; g.be = be;
    g.chk_wd = chk_wd; g.wdata = wdata;
    gq.push_back(g);
  endtask

  task automatic push_rsp(bit dm, int c, logic [31:0] data);
    rsp_t r;
    r.dm = dm; r.cyc = c; r.data = data;
    rq.push_back(r);
  endtask

  task automatic drain();
    int n = 0;
    while ((gq.size() != 0 || rq.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    if (gq.size() != 0 || rq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d grants and %0d responses outstanding, required 0",
               gq.size(), rq.size());
      gq.delete();
      rq.delete();
    end
    tick();
  endtask

  initial begin
    int c0;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h200;
    bus.dm_wdata = '0; bus.dm_be = 4'hF;

    // Reset with both requests raised: nothing may be granted or completed.
    repeat (3) tick();
    chk("reset_if_gnt", {31'b0, bus.if_gnt}, 32'd0);
    chk("reset_dm_gnt", {31'b0, bus.dm_gnt}, 32'd0);
    chk("reset_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("reset_rvalid", {30'b0, bus.if_rvalid, bus.dm_rvalid}, 32'd0);
    chk("reset_rdata", bus.if_rdata | bus.dm_rdata, 32'd0);
    bus.if_req = 1'b0; bus.dm_req = 1'b0; rstb = 1'b0;
    tick();

    // 1: single IF fetch
    tick(); c0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    push_gnt(1'b0, c0, 32'h100, 1'b0, 4'hF, 1'b0, '0);
    push_rsp(1'b0, c0 + 2, 32'hDEADBEEF);
    tick(); bus.if_req = 1'b0;
    drain();

    // 2: IF and DM together, DM wins
    tick(); c0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h200; bus.dm_be = 4'hF;
    push_gnt(1'b1, c0, 32'h200, 1'b0, 4'hF, 1'b0, '0);
    push_gnt(1'b0, c0 + 3, 32'h300, 1'b0, 4'hF, 1'b0, '0);
    push_rsp(1'b1, c0 + 2, mem_val(32'h200));
    push_rsp(1'b0, c0 + 5, mem_val(32'h300));
    tick(); bus.dm_req = 1'b0;
    repeat (3) tick();
    bus.if_req = 1'b0;
    drain();
`ifdef PHILV_ARB_PERF_EN
    chk("perf_if_wait", perf_if_wait, 32'd3);
    chk("perf_dm_wait", perf_dm_wait, 32'd0);
`endif

    // 3: both held, starvation guard forces IF on the fifth grant
    tick(); c0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        push_gnt(1'b0, c0 + 3 * k, 32'h300, 1'b0, 4'hF, 1'b0, '0);
        push_rsp(1'b0, c0 + 3 * k + 2, mem_val(32'h300));
      end else begin
        push_gnt(1'b1, c0 + 3 * k, 32'h200, 1'b0, 4'hF, 1'b0, '0);
        push_rsp(1'b1, c0 + 3 * k + 2, mem_val(32'h200));
      end
    end
    repeat (16) tick();
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    drain();

    // 4: partial store, ack carries zero data
    tick(); c0 = cyc;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40;
    bus.dm_wdata = 32'hCAFEF00D; bus.dm_be = 4'b0011;
    push_gnt(1'b1, c0, 32'h40, 1'b1, 4'b0011, 1'b1, 32'hCAFEF00D);
    push_rsp(1'b1, c0 + 2, 32'd0);
    tick(); bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = 4'hF;
    drain();

    // 5: reset while BUSY drops the pending fetch; held request is re-granted
    tick(); c0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    push_gnt(1'b0, c0, 32'h100, 1'b0, 4'hF, 1'b0, '0);
    tick(); rstb = 1'b1;
    tick(); rstb = 1'b0;
    push_gnt(1'b0, c0 + 2, 32'h100, 1'b0, 4'hF, 1'b0, '0);
    push_rsp(1'b0, c0 + 4, 32'hDEADBEEF);
    tick(); bus.if_req = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
